// File: rtl/rom_pkg.sv
// ---------------------------------------------------------------------------
// rom_pkg
// Shared definitions for the rom_simple burst reader slice:
//   - default width localparams for the data, address and burst-length fields
//   - the reader FSM state enum
// ---------------------------------------------------------------------------
package rom_pkg;

   localparam int unsigned ROM_DATA_WIDTH_DEF = 8;
   localparam int unsigned ROM_ADDR_WIDTH_DEF = 8;
   localparam int unsigned ROM_LEN_WIDTH_DEF  = 8;

   typedef enum logic [0:0] {
      ROM_RD_IDLE = 1'b0,
      ROM_RD_RUN  = 1'b1
   } rom_rd_state_e;

endpackage

// File: rtl/rom_out_reg.sv
// ---------------------------------------------------------------------------
// rom_out_reg
// One-entry registered output stage with valid/ready handshake.
//   clk      in   rising-edge clock
//   rst      in   synchronous active-high reset
//   i_load   in   capture i_data/i_last this cycle (only asserted when o_free)
//   i_data   in   word to capture
//   i_last   in   last-beat marker to capture
//   i_ready  in   downstream consumer accepts the held word
//   o_valid  out  held word is valid
//   o_data   out  held word
//   o_last   out  held last-beat marker
//   o_free   out  register may be loaded this cycle (empty or draining)
// ---------------------------------------------------------------------------
module rom_out_reg
   import rom_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = ROM_DATA_WIDTH_DEF
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  i_load,
   input  logic [DATA_WIDTH-1:0] i_data,
   input  logic                  i_last,
   input  logic                  i_ready,
   output logic                  o_valid,
   output logic [DATA_WIDTH-1:0] o_data,
   output logic                  o_last,
   output logic                  o_free
);

   logic                  r_valid;
   logic [DATA_WIDTH-1:0] r_data;
   logic                  r_last;

   assign o_free  = !r_valid || i_ready;
   assign o_valid = r_valid;
   assign o_data  = r_data;
   assign o_last  = r_last;

   // Data/last only change on a load, so they stay stable while stalled.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_valid <= 1'b0;
         r_data  <= '0;
         r_last  <= 1'b0;
      end else if (i_load) begin
         r_valid <= 1'b1;
         r_data  <= i_data;
         r_last  <= i_last;
      end else if (i_ready) begin
         r_valid <= 1'b0;
      end
   end

endmodule

// File: rtl/rom_burst_reader.sv
// ---------------------------------------------------------------------------
// rom_burst_reader
// Address sequencer for rom_simple. Accepts a burst request (start address,
// length-1), walks rom_addr sequentially (modulo 2^ADDR_WIDTH), registers the
// combinational ROM word and streams it out with valid/ready and a last flag.
// One word per cycle when the consumer does not stall.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   req_valid/req_ready      burst request handshake (ready only in IDLE)
//   req_addr  [ADDR_WIDTH]   first word address
//   req_len   [LEN_WIDTH]    word count minus one
//   rom_addr  [ADDR_WIDTH]   address to rom_simple
//   rom_data  [DATA_WIDTH]   combinational data from rom_simple
//   out_valid/out_ready      output word handshake
//   out_data  [DATA_WIDTH]   ROM word
//   out_last                 final word of the burst
//   out_xsum  [DATA_WIDTH]   running XOR of the burst's words (optional)
//   busy                     high in RUN or while out_valid
//
// Optional feature macro: ROM_BURST_READER_CHECKSUM_EN adds out_xsum.
// ---------------------------------------------------------------------------
module rom_burst_reader
   import rom_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = ROM_DATA_WIDTH_DEF,
   parameter int unsigned ADDR_WIDTH = ROM_ADDR_WIDTH_DEF,
   parameter int unsigned LEN_WIDTH  = ROM_LEN_WIDTH_DEF
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [LEN_WIDTH-1:0]  req_len,
   output logic [ADDR_WIDTH-1:0] rom_addr,
   input  logic [DATA_WIDTH-1:0] rom_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  out_last,
`ifdef ROM_BURST_READER_CHECKSUM_EN
   output logic [DATA_WIDTH-1:0] out_xsum,
`endif
   output logic                  busy
);

   rom_rd_state_e         r_state;
   rom_rd_state_e         w_state_nxt;
   logic [ADDR_WIDTH-1:0] r_cur_addr;
   logic [LEN_WIDTH-1:0]  r_remaining;
   logic                  w_accept;
   logic                  w_load;
   logic                  w_free;
   logic                  w_last_beat;

   assign w_last_beat = (r_remaining == '0);
   assign rom_addr    = r_cur_addr;
   assign busy        = (r_state == ROM_RD_RUN) || out_valid;

   // ------------------------------------------------------------------
   // FSM
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ROM_RD_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_accept    = 1'b0;
      w_load      = 1'b0;
      req_ready   = 1'b0;
      case (r_state)
         ROM_RD_IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               w_accept    = 1'b1;
               w_state_nxt = ROM_RD_RUN;
            end
         end
         ROM_RD_RUN: begin
            if (w_free) begin
               w_load = 1'b1;
               if (w_last_beat) begin
                  w_state_nxt = ROM_RD_IDLE;
               end
            end
         end
         default: begin
            w_state_nxt = ROM_RD_IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // Address / length counters
   // ------------------------------------------------------------------
   // The last beat does not advance the address: rom_addr then keeps
   // showing the final word's address through IDLE, and the counter value
   // past the end of the burst is never observed anyway.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_cur_addr  <= '0;
         r_remaining <= '0;
      end else if (w_accept) begin
         r_cur_addr  <= req_addr;
         r_remaining <= req_len;
      end else if (w_load && !w_last_beat) begin
         r_cur_addr  <= r_cur_addr + ADDR_WIDTH'(1);
         r_remaining <= r_remaining - LEN_WIDTH'(1);
      end
   end

   // ------------------------------------------------------------------
   // Output register
   // ------------------------------------------------------------------
   rom_out_reg #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_out_reg (
      .clk     (clk),
      .rst     (rst),
      .i_load  (w_load),
      .i_data  (rom_data),
      .i_last  (w_last_beat),
      .i_ready (out_ready),
      .o_valid (out_valid),
      .o_data  (out_data),
      .o_last  (out_last),
      .o_free  (w_free)
   );

`ifdef ROM_BURST_READER_CHECKSUM_EN
   // ------------------------------------------------------------------
   // Running XOR, updated in step with the output register load so it
   // always includes the word currently in out_data.
   // ------------------------------------------------------------------
   logic [DATA_WIDTH-1:0] r_xsum;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_xsum <= '0;
      end else if (w_accept) begin
         r_xsum <= '0;
      end else if (w_load) begin
         r_xsum <= r_xsum ^ rom_data;
      end
   end

   assign out_xsum = r_xsum;
`endif

endmodule

// File: tb/tb_rom_burst_reader.sv
module tb_rom_burst_reader;

   logic       clk = 1'b0;
   logic       rst;
   logic       req_valid;
   logic       req_ready;
   logic [7:0] req_addr;
   logic [7:0] req_len;
   logic [7:0] rom_addr;
   logic [7:0] rom_data;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] out_data;
   logic       out_last;
   logic       busy;
`ifdef ROM_BURST_READER_CHECKSUM_EN
   logic [7:0] out_xsum;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   // ROM contents: ROM[i] = i ^ 0xA5
   logic [7:0] rom_mem [256];
   initial begin
      for (int i = 0; i < 256; i++) rom_mem[i] = 8'(i) ^ 8'hA5;
   end
   assign rom_data = rom_mem[rom_addr];

   rom_burst_reader #(
      .DATA_WIDTH (8),
      .ADDR_WIDTH (8),
      .LEN_WIDTH  (8)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_addr  (req_addr),
      .req_len   (req_len),
      .rom_addr  (rom_addr),
      .rom_data  (rom_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_last  (out_last),
`ifdef ROM_BURST_READER_CHECKSUM_EN
      .out_xsum  (out_xsum),
`endif
      .busy      (busy)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // ------------------------------------------------------------------
   // Reference model / scoreboard: every accepted request expands into
   // its list of expected words (address wraps at 8 bits), each with the
   // last flag and the running XOR up to that word.
   // ------------------------------------------------------------------
   typedef struct {
      logic [7:0] d;
      logic       l;
      logic [7:0] x;
   } exp_t;

   exp_t       exp_q[$];
   exp_t       m_e;
   logic [7:0] m_x;
   logic       prev_stall = 1'b0;
   logic       prev_acc   = 1'b0;
   logic [7:0] prev_d, prev_a;
   logic       prev_l;

   always @(negedge clk) begin
      if (rst) begin
         exp_q.delete();
         prev_stall = 1'b0;
         prev_acc   = 1'b0;
      end else begin
         if (prev_stall) begin
            chk("stall_valid", 32'(out_valid), 32'd1);
            chk("stall_data", 32'(out_data), 32'(prev_d));
            chk("stall_last", 32'(out_last), 32'(prev_l));
            if (!prev_acc) chk("stall_rom_addr", 32'(rom_addr), 32'(prev_a));
         end
         chk("busy", 32'(busy), 32'(!req_ready || out_valid));
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               chk("spurious_beat", 32'd1, 32'd0);
            end else begin
               m_e = exp_q.pop_front();
               chk("beat_data", 32'(out_data), 32'(m_e.d));
               chk("beat_last", 32'(out_last), 32'(m_e.l));
`ifdef ROM_BURST_READER_CHECKSUM_EN
               chk("beat_xsum", 32'(out_xsum), 32'(m_e.x));
`endif
            end
         end
         if (req_valid && req_ready) begin
            m_x = 8'h00;
            for (int k = 0; k <= int'(req_len); k++) begin
               m_e.d = rom_mem[8'(int'(req_addr) + k)];
               m_x   = m_x ^ m_e.d;
               m_e.x = m_x;
               m_e.l = (k == int'(req_len));
               exp_q.push_back(m_e);
            end
         end
         prev_stall = out_valid && !out_ready;
         prev_acc   = req_valid && req_ready;
         prev_d     = out_data;
         prev_l     = out_last;
         prev_a     = rom_addr;
      end
   end

   // ------------------------------------------------------------------
   // Run one burst. mode 0: out_ready high, 1: pattern 1,0,0,1,...,
   // 2: random. Sample n counts negedges after the acceptance sample.
   // ------------------------------------------------------------------
   task automatic do_burst(input logic [7:0] a, input logic [7:0] l, input int mode,
                           output int lat, output int rdy_low, output int beats,
                           output logic [7:0] fd, output logic [7:0] ld);
      bit acc  = 0;
      bit done = 0;
      int n    = 0;
      lat = -1; rdy_low = 0; beats = 0; fd = 8'h00; ld = 8'h00;
      req_addr = a; req_len = l; req_valid = 1'b1;
      for (int c = 0; c < 1000 && !done; c++) begin
         case (mode)
            0:       out_ready = 1'b1;
            1:       out_ready = (c % 4 == 0) || (c % 4 == 3);
            default: out_ready = 1'($urandom % 2);
         endcase
         @(negedge clk);
         if (!acc) begin
            if (req_ready) acc = 1;
         end else begin
            n++;
            if (!req_ready) rdy_low++;
            if (out_valid && lat < 0) begin
               lat = n;
               fd  = out_data;
            end
            if (out_valid && out_ready) begin
               beats++;
               if (out_last) begin
                  ld   = out_data;
                  done = 1;
               end
            end
         end
         @(posedge clk); #1;
         if (acc) req_valid = 1'b0;
      end
      req_valid = 1'b0;
      if (!done) chk("burst_timeout", 32'd0, 32'd1);
   endtask

   typedef struct {
      logic [7:0] addr;
      logic [7:0] len;
      int         mode;
      logic [7:0] exp_first;
      logic [7:0] exp_last;
      int         exp_beats;
   } vec_t;

   vec_t       vecs[6];
   int         lat, rdy_low, beats, nb, acc2n, n;
   logic [7:0] fd, ld, obs;
   logic [7:0] ra;
   logic [7:0] rl;
   bit         acc;

   initial begin
      vecs[0] = '{8'h10, 8'd0,   0, 8'hB5, 8'hB5, 1};
      vecs[1] = '{8'h20, 8'd7,   0, 8'h85, 8'h82, 8};
      vecs[2] = '{8'h30, 8'd3,   1, 8'h95, 8'h96, 4};
      vecs[3] = '{8'hFE, 8'd3,   0, 8'h5B, 8'hA4, 4};
      vecs[4] = '{8'h80, 8'd0,   1, 8'h25, 8'h25, 1};
      vecs[5] = '{8'h00, 8'd255, 0, 8'hA5, 8'h5A, 256};

      rst = 1'b1; req_valid = 1'b0; req_addr = 8'h00; req_len = 8'h00; out_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("rst_rom_addr",  32'(rom_addr),  32'h0);
      chk("rst_out_valid", 32'(out_valid), 32'h0);
      chk("rst_out_data",  32'(out_data),  32'h0);
      chk("rst_out_last",  32'(out_last),  32'h0);
      chk("rst_req_ready", 32'(req_ready), 32'h1);
      chk("rst_busy",      32'(busy),      32'h0);
      @(posedge clk); #1;

      // table-driven bursts
      foreach (vecs[i]) begin
         do_burst(vecs[i].addr, vecs[i].len, vecs[i].mode, lat, rdy_low, beats, fd, ld);
         chk("vec_latency", 32'(lat), 32'd2);
         chk("vec_first",   32'(fd),  32'(vecs[i].exp_first));
         chk("vec_last",    32'(ld),  32'(vecs[i].exp_last));
         chk("vec_beats",   32'(beats), 32'(vecs[i].exp_beats));
         if (vecs[i].mode == 0) chk("vec_req_ready_low", 32'(rdy_low), 32'(vecs[i].exp_beats));
         @(posedge clk); #1;
         chk("vec_drained", 32'(exp_q.size()), 32'd0);
      end

      // reset mid-burst after the 4th beat
      req_addr = 8'h60; req_len = 8'd15; req_valid = 1'b1; out_ready = 1'b1;
      acc = 0; nb = 0;
      for (int c = 0; c < 100 && nb < 4; c++) begin
         @(negedge clk);
         if (!acc) begin
            if (req_ready) acc = 1;
         end else if (out_valid) begin
            nb++;
         end
         @(posedge clk); #1;
         if (acc) req_valid = 1'b0;
      end
      chk("midrst_beats_before", 32'(nb), 32'd4);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("midrst_out_valid", 32'(out_valid), 32'd0);
      chk("midrst_out_last",  32'(out_last),  32'd0);
      chk("midrst_req_ready", 32'(req_ready), 32'd1);
      chk("midrst_busy",      32'(busy),      32'd0);
      @(posedge clk); #1;
      do_burst(8'h40, 8'd0, 0, lat, rdy_low, beats, fd, ld);
      chk("midrst_new_data",  32'(fd), 32'hE5);
      chk("midrst_new_beats", 32'(beats), 32'd1);
      @(posedge clk); #1;

      // back-to-back requests with req_valid held
      req_valid = 1'b1; req_addr = 8'h50; req_len = 8'd2; out_ready = 1'b1;
      acc = 0; acc2n = -1; obs = 8'h00; n = 0;
      for (int c = 0; c < 40 && n < 8; c++) begin
         @(negedge clk);
         if (!acc) begin
            if (req_ready) acc = 1;
         end else begin
            n++;
            obs = {obs[6:0], out_valid};
            if (acc2n < 0 && req_ready) begin
               acc2n = n;
               chk("b2b_last_pending", 32'(out_valid && out_last), 32'd1);
            end
         end
         @(posedge clk); #1;
         if (acc && n == 0) begin
            req_addr = 8'h70; req_len = 8'd1;
         end
         if (acc2n > 0) req_valid = 1'b0;
      end
      req_valid = 1'b0;
      chk("b2b_accept_sample", 32'(acc2n), 32'd4);
      chk("b2b_valid_pattern", 32'(obs), 32'(8'b0111_0110));
      @(posedge clk); #1;
      chk("b2b_drained", 32'(exp_q.size()), 32'd0);

      // randomized bursts under random backpressure
      for (int r = 0; r < 25; r++) begin
         ra = 8'($urandom);
         rl = 8'($urandom_range(0, 15));
         repeat ($urandom_range(0, 3)) begin
            out_ready = 1'($urandom % 2);
            @(posedge clk); #1;
         end
         do_burst(ra, rl, 2, lat, rdy_low, beats, fd, ld);
         chk("rand_latency", 32'(lat), 32'd2);
         chk("rand_beats", 32'(beats), 32'(int'(rl) + 1));
      end
      @(posedge clk); #1;
      chk("rand_drained", 32'(exp_q.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
